board_writer: RTL
=================

Name: board_writer

Overview:
- Write side of the `serialized_board` interface that the VGA display reads.
- Accepts a move request (source square, destination square, current legal-move list) from the cursor/selection path and checks it.
- Applies the move to the 64-square board register: relocate piece, remove jumped piece, promote to king.
- Toggles the side to move and counts turns; sits between the cursor_control/legal-move generator and display.

Parameters:
- INIT_ROWS, 3, number of rows per side filled with men at reset.
- TURN_W, 8, width of turn counter.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- move_valid  input  1  one-cycle request strobe
- src_loc  input  6  source square, {row[2:0], col[2:0]}
- dst_loc  input  6  destination square, same encoding
- legal_move  input  28  4 slots × 7 bits, slot k = bits [7k+6:7k] = {valid, loc[5:0]}
- serialized_board  output  192  square n occupies bits [3n+2:3n]
- turn  output  1  side to move: 0 = red, 1 = black
- turn_count  output  TURN_W  completed moves
- busy  output  1  high whenever FSM is not IDLE
- move_done  output  1  one-cycle pulse: move committed
- move_err  output  1  one-cycle pulse: move rejected

Behaviour:
- Piece codes: 0 empty, 1 red man, 2 red king, 3 black man, 4 black king. Codes 5–7 are never written.
- Dark squares are those with (row+col) odd.
- Reset (sync, any state):
  - Dark squares in rows 0..INIT_ROWS-1 = 1.
  - Dark squares in rows 8-INIT_ROWS..7 = 3.
  - All other squares = 0.
  - turn=0, turn_count=0, busy=0, move_done=0, move_err=0, FSM=IDLE, latched regs=0.
- FSM states: IDLE, CHECK, WRITE, DONE, ERR.
- IDLE:
  - move_valid=1 latches src_loc, dst_loc, legal_move; go to CHECK.
  - move_valid in any other state is ignored; no queueing.
- CHECK (combinational validator on latched values): legal iff all of:
  - src piece belongs to `turn` (red: 1/2; black: 3/4);
  - dst square is empty;
  - dst equals loc of at least one slot with valid=1;
  - src≠dst.
  - Legal → WRITE; otherwise → ERR.
- WRITE, single cycle, all updates in the same cycle:
  - dst ← src piece; src ← 0.
  - If |row(dst)-row(src)|==2 (jump): square (src+dst)>>1 ← 0.
  - Promotion overrides the copied code: red man landing on row 7 becomes 2; black man landing on row 0 becomes 4.
  - Kings are never demoted.
  - Next state DONE.
- DONE:
  - move_done=1 for this cycle; turn toggles; turn_count increments, wrapping at 2^TURN_W.
  - Next state IDLE.
- ERR:
  - move_err=1 for this cycle; board, turn and turn_count unchanged.
  - Next state IDLE.
- Latency, with request accepted at cycle 0:
  - board update visible from cycle 3 (registered in WRITE at end of cycle 2);
  - move_done high in cycle 3;
  - move_err high in cycle 2.
  - busy high in cycles 1..3 (legal move) or 1..2 (rejected move).
- Multi-jump continuation is not handled here: every committed move toggles turn.
- serialized_board is a direct register output; no combinational path from inputs.
- Reset asserted mid-operation aborts the move. Board returns to the initial layout on the next edge; no done/err pulse.
- Simultaneous move_valid and rst: rst wins.

Decomposition:
- Shared package checker_pkg holds:
  - piece code constants (EMPTY, RED_MAN, RED_KING, BLK_MAN, BLK_KING);
  - LOC_W=6, SQ_W=3, MOVE_SLOTS=4, SLOT_W=7;
  - FSM state enum;
  - row/col extraction helpers;
  - INIT_BOARD constant, which game_logic reuses.
- One sub-module: move_validator, purely combinational. Inputs: board, turn, src, dst, legal_move. Output: legal.

Test Plan:
- Reset: rst=1 for 2 cycles → square 1=1, 17=1, 40=3, 62=3, 0=0, 27=0; turn=0; turn_count=0; busy=0.
- Simple move: move_valid with src=17, dst=26, slot0={1,26} → cycle 3 move_done=1; square17=0, square26=1; turn=1; turn_count=1.
- Reject wrong side or absent dst:
  - turn=0, src=40 (black) → move_err at cycle 2, board unchanged, turn stays 0.
  - src=17, dst=26 with all slot valid bits 0 → move_err.
- Capture: sequence 17→26 (red), 40→33 (black), 26→35? (jump blocked), then red 21→28, black 42→35, red 28→42 with slot={1,42} → square35=0, square42=1, turn toggles.
- Promotion: drive a red man by legal moves until a jump lands on row 7 (e.g. dst=58) → square58=2 and the promoted code persists on later moves.
- Busy/reset:
  - Second move_valid during cycles 1–3 → ignored, exactly one move_done.
  - rst asserted in WRITE → initial board, no move_done, turn_count=0.

Source files
------------

// File: rtl/checker_pkg.sv
// checker_pkg: shared definitions for the checkers board write path.
// Holds piece codes, geometry widths, the board-writer FSM state type,
// square-coordinate helpers and the reset board layout.
package checker_pkg;

  localparam int LOC_W      = 6;   // {row[2:0], col[2:0]}
  localparam int SQ_W       = 3;   // bits per square in the serialized board
  localparam int MOVE_SLOTS = 4;
  localparam int SLOT_W     = 7;   // {valid, loc[5:0]}
  localparam int NUM_SQ     = 64;
  localparam int BOARD_W    = NUM_SQ * SQ_W;

  localparam logic [SQ_W-1:0] EMPTY    = 3'd0;
  localparam logic [SQ_W-1:0] RED_MAN  = 3'd1;
  localparam logic [SQ_W-1:0] RED_KING = 3'd2;
  localparam logic [SQ_W-1:0] BLK_MAN  = 3'd3;
  localparam logic [SQ_W-1:0] BLK_KING = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  function automatic logic [2:0] loc_row(input logic [LOC_W-1:0] loc);
    return loc[5:3];
  endfunction

  function automatic logic [2:0] loc_col(input logic [LOC_W-1:0] loc);
    return loc[2:0];
  endfunction

  // Absolute row distance between two squares; 2 means a jump.
  function automatic logic [2:0] row_dist(input logic [LOC_W-1:0] a,
                                          input logic [LOC_W-1:0] b);
    return (loc_row(a) > loc_row(b)) ? loc_row(a) - loc_row(b)
                                     : loc_row(b) - loc_row(a);
  endfunction

  // Starting layout: men on the dark squares of the first/last `rows` rows.
  function automatic logic [BOARD_W-1:0] build_board(input int rows);
    logic [BOARD_W-1:0] b;
    int r;
    int c;
    b = '0;
    for (int n = 0; n < NUM_SQ; n++) begin
      r = n / 8;
      c = n % 8;
      if ((r + c) % 2 == 1) begin
        if (r < rows)          b[n*SQ_W +: SQ_W] = RED_MAN;
        else if (r >= 8 - rows) b[n*SQ_W +: SQ_W] = BLK_MAN;
      end
    end
    return b;
  endfunction

  localparam int                 INIT_ROWS_DEF = 3;
  localparam logic [BOARD_W-1:0] INIT_BOARD    = build_board(INIT_ROWS_DEF);

endpackage

// File: rtl/board_writer_if.sv
// board_writer_if: move-request handshake between the cursor/selection path
// (master) and the board writer (slave).
//   move_valid            one-cycle request strobe
//   src_loc / dst_loc     source / destination square {row, col}
//   legal_move            4 slots of {valid, loc}
//   busy                  writer is processing a request
//   move_done / move_err  one-cycle commit / reject pulses
interface board_writer_if;
  import checker_pkg::*;

  logic                         move_valid;
  logic [LOC_W-1:0]             src_loc;
  logic [LOC_W-1:0]             dst_loc;
  logic [MOVE_SLOTS*SLOT_W-1:0] legal_move;
  logic                         busy;
  logic                         move_done;
  logic                         move_err;

  modport master (
    output move_valid, src_loc, dst_loc, legal_move,
    input  busy, move_done, move_err
  );

  modport slave (
    input  move_valid, src_loc, dst_loc, legal_move,
    output busy, move_done, move_err
  );

endinterface

// File: rtl/move_validator.sv
// move_validator: purely combinational legality check of a latched move.
//   board       current serialized board
//   turn        side to move (0 red, 1 black)
//   src / dst   move squares
//   legal_move  candidate destination slots {valid, loc}
//   legal       move may be applied
module move_validator
  import checker_pkg::*;
(
  input  logic [BOARD_W-1:0]             board,
  input  logic                           turn,
  input  logic [LOC_W-1:0]               src,
  input  logic [LOC_W-1:0]               dst,
  input  logic [MOVE_SLOTS*SLOT_W-1:0]   legal_move,
  output logic                           legal
);

  logic [SQ_W-1:0] src_pc;
  logic [SQ_W-1:0] dst_pc;
  logic            own;
  logic            hit;

  always_comb begin
    src_pc = board[int'(src)*SQ_W +: SQ_W];
    dst_pc = board[int'(dst)*SQ_W +: SQ_W];
    own    = turn ? (src_pc == BLK_MAN || src_pc == BLK_KING)
                  : (src_pc == RED_MAN || src_pc == RED_KING);
    hit    = 1'b0;
    for (int k = 0; k < MOVE_SLOTS; k++) begin
      if (legal_move[k*SLOT_W + LOC_W] && legal_move[k*SLOT_W +: LOC_W] == dst)
        hit = 1'b1;
    end
    legal = own && (dst_pc == EMPTY) && hit && (src != dst);
  end

endmodule

// File: rtl/board_writer.sv
// board_writer: write side of the serialized checkers board.
// Latches a move request, validates it, applies it to the 64-square board
// (relocate, capture, promote), then toggles the side to move.
//   clk, rst          clock, synchronous active-high reset
//   bus               request/status handshake (slave side)
//   serialized_board  square n at bits [3n+2:3n], registered
//   turn              side to move (0 red, 1 black)
//   turn_count        committed moves, wraps
module board_writer
  import checker_pkg::*;
#(
  parameter int INIT_ROWS = 3,
  parameter int TURN_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  board_writer_if.slave       bus,
  output logic [BOARD_W-1:0]  serialized_board,
  output logic                turn,
  output logic [TURN_W-1:0]   turn_count
);

  localparam logic [BOARD_W-1:0] RESET_BOARD =
    (INIT_ROWS == INIT_ROWS_DEF) ? INIT_BOARD : build_board(INIT_ROWS);

  state_t                       state, state_nx;
  logic [LOC_W-1:0]             src_q, dst_q;
  logic [MOVE_SLOTS*SLOT_W-1:0] moves_q;
  logic                         legal;
  logic [BOARD_W-1:0]           board_nx;
  logic [SQ_W-1:0]              piece;
  logic [LOC_W-1:0]             mid_loc;

  move_validator u_validator (
    .board      (serialized_board),
    .turn       (turn),
    .src        (src_q),
    .dst        (dst_q),
    .legal_move (moves_q),
    .legal      (legal)
  );

  // NOTE: every variable written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx      = state;
    bus.busy      = (state != S_IDLE);
    bus.move_done = 1'b0;
    bus.move_err  = 1'b0;
    unique case (state)
      S_IDLE:  if (bus.move_valid) state_nx = S_CHECK;
      S_CHECK: state_nx = legal ? S_WRITE : S_ERR;
      S_WRITE: state_nx = S_DONE;
      S_DONE: begin
        bus.move_done = 1'b1;
        state_nx      = S_IDLE;
      end
      S_ERR: begin
        bus.move_err = 1'b1;
        state_nx     = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Board after the latched move. Promotion replaces the copied code; a
  // king is never matched by the man comparisons, so it cannot be demoted.
  always_comb begin
    piece = serialized_board[int'(src_q)*SQ_W +: SQ_W];
    if (piece == RED_MAN && loc_row(dst_q) == 3'd7)
      piece = RED_KING;
    else if (piece == BLK_MAN && loc_row(dst_q) == 3'd0)
      piece = BLK_KING;
    // Jumped square is the index midpoint of source and destination.
    mid_loc  = LOC_W'((int'(src_q) + int'(dst_q)) >> 1);
    board_nx = serialized_board;
    board_nx[int'(src_q)*SQ_W +: SQ_W] = EMPTY;
    if (row_dist(src_q, dst_q) == 3'd2)
      board_nx[int'(mid_loc)*SQ_W +: SQ_W] = EMPTY;
    board_nx[int'(dst_q)*SQ_W +: SQ_W] = piece;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      // NOTE: the board is state the game depends on, so it is reset
      // explicitly to the opening layout rather than left undefined.
      serialized_board <= RESET_BOARD;
      turn             <= 1'b0;
      turn_count       <= '0;
      src_q            <= '0;
      dst_q            <= '0;
      moves_q          <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && bus.move_valid) begin
        src_q   <= bus.src_loc;
        dst_q   <= bus.dst_loc;
        moves_q <= bus.legal_move;
      end
      if (state == S_WRITE)
        serialized_board <= board_nx;
      if (state == S_DONE) begin
        turn       <= ~turn;
        turn_count <= turn_count + 1'b1;
      end
    end
  end

endmodule
